led_status_ctrl: RTL
====================

# led_status_ctrl

Parametrised multi-channel status-LED controller for the afm top level. It replaces the fixed 6-bit LED drive with NUM_LEDS independent channels. Each channel is runtime-configurable as off, on, blink or PWM breathe. All timing derives from a single system clock through a shared tick prescaler. The block sits between the PLL-clocked core logic and the bank3 1.8 V LED pins.

## Interface
Parameters:
- NUM_LEDS, 6: number of LED channels (1..16).
- CLK_FREQ_HZ, 27_000_000: frequency of clk.
- TICK_HZ, 1000: rate of the internal time-base tick.
- PWM_BITS, 8: breathe brightness and PWM resolution.
- ACTIVE_LOW, 1: 1 drives lit LED as 0, 0 drives lit LED as 1.
- HEARTBEAT, 1: 1 makes channel 0 reset into BLINK with period 250.

Ports:
- clk  in  1  system clock. One clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  configuration write strobe, single cycle.
- cfg_ch  in  CW  target channel; CW = max(1, $clog2(NUM_LEDS)).
- cfg_mode  in  2  mode code: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- cfg_period  in  8  blink half-period, or breathe step interval, in ticks.
- cfg_ack  out  1  one-cycle pulse when a write is accepted.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- tick_o  out  1  one-cycle time-base pulse, exported for other blocks.
- led_o  out  NUM_LEDS  LED pin drive, registered.

## Operation
- Prescaler: counter runs 0..DIV-1, where DIV = CLK_FREQ_HZ/TICK_HZ (integer, must be ≥2). The tick pulse asserts on the cycle the counter equals DIV-1, then the counter wraps to 0.
- Per-channel state: mode[1:0], period[7:0], tick counter[7:0], phase bit, level[PWM_BITS-1:0], dir bit.
- Effective period: a stored period of 0 is treated as 1.
- OFF: channel unlit.
- ON: channel lit.
- BLINK: on each tick the tick counter increments. When it reaches effective period − 1, it clears to 0 and phase toggles. The channel is lit when phase = 1.
- BREATHE, tick handling: same tick/period cadence as BLINK. Each period expiry steps level by ±1.
- BREATHE, direction: dir = up increments to 2^PWM_BITS−1, then dir flips to down. dir = down decrements to 0, then dir flips to up. The endpoints are held for exactly one step, giving a triangle wave.
- BREATHE, PWM: a shared free-running PWM counter[PWM_BITS-1:0] increments every clk. The channel is lit when pwm_cnt < level, so level 0 is fully dark.
- Config write, valid: when cfg_we = 1 and cfg_ch < NUM_LEDS, store mode and period, clear the tick counter, phase, level and dir (dir = up), and pulse cfg_ack.
- Config write, invalid: when cfg_ch ≥ NUM_LEDS, state is unchanged and cfg_err pulses.
- Tick/write collision: a write and a tick in the same cycle is handled write-wins for the written channel; that channel ignores the tick. All other channels process the tick normally.
- Output polarity: led_o[i] = lit[i] XOR ACTIVE_LOW, registered.

## Timing
- Reset values: all modes OFF, all counters and levels 0, phase 0, dir up, cfg_ack = 0, cfg_err = 0, tick_o = 0, led_o = all channels unlit (all ones when ACTIVE_LOW = 1).
- HEARTBEAT reset: if HEARTBEAT = 1, channel 0 resets to mode BLINK, period 250.
- Reset mid-operation: asynchronous assertion forces the reset values immediately, with no dependency on clk. Deassertion is taken synchronously by downstream logic; the tick counter restarts from 0.
- Write latency: cfg_ack/cfg_err assert on the clk edge after the cfg_we cycle. The new mode appears on led_o one further cycle later (2 cycles total).
- Mode change latency: a write switching a channel to ON/OFF updates led_o 2 cycles after cfg_we.
- Blink timing: the first toggle after a write occurs at the effective-period-th tick. The full blink cycle is 2·P ticks.
- Writes are allowed back-to-back, every cycle; each one is acknowledged.

## Configuration
- LED_BREATHE_EN defined: BREATHE mode, the PWM counter and the level/dir registers are built.
- LED_BREATHE_EN undefined: that logic is removed. Mode 3 is still accepted (cfg_ack pulses) but behaves as ON.

## Test plan
Bench parameters for all scenarios: CLK_FREQ_HZ = 1000, TICK_HZ = 100, giving DIV = 10.
- Reset: hold rst_n = 0, then release. Expect led_o = 6'b111111 until the first channel-0 toggle, and tick_o pulsing every 10 clk.
- HEARTBEAT: after reset, led_o[0] toggles every 250 ticks (2500 clk); all other bits stay 1.
- BLINK write: cfg_ch = 2, mode 2, period 3. Expect cfg_ack 1 cycle later, and led_o[2] toggling every 30 clk.
- Invalid channel: cfg_ch = 7. Expect cfg_err = 1, cfg_ack = 0, and no change on led_o.
- BREATHE, with LED_BREATHE_EN defined: cfg_ch = 1, mode 3, period 1. Expect level to reach 255 after 255 ticks. Duty of led_o[1] is low for level/256 of each 256-clk window, and it returns to 0 after 510 ticks.
- Collision: a write to ch 3 lands on a tick cycle. Expect the ch 3 counter to be 0 afterward, while other BLINK channels still advance.

Source files
------------

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED controller: per-channel OFF / ON / BLINK / BREATHE driven from a shared tick.
// Define LED_BREATHE_EN to build the PWM breathe engine; without it, mode 3 is accepted and acts as ON.
module led_status_ctrl #(
   parameter int NUM_LEDS    = 6,
   parameter int CLK_FREQ_HZ = 27_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int PWM_BITS    = 8,
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter bit HEARTBEAT   = 1'b1
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic                                                  cfg_we,
   input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0]    cfg_ch,
   input  logic [1:0]                                            cfg_mode,
   input  logic [7:0]                                            cfg_period,
   output logic                                                  cfg_ack,
   output logic                                                  cfg_err,
   output logic                                                  tick_o,
   output logic [NUM_LEDS-1:0]                                   led_o
);

   localparam int CW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   logic [PW-1:0]       presc_cnt;
   logic                tick;
   logic                wr_valid;
   logic [NUM_LEDS-1:0] lit;

   assign tick     = (presc_cnt == DIV_LAST);
   assign tick_o   = tick;
   assign wr_valid = cfg_we && (32'(cfg_ch) < NUM_LEDS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
      end else if (tick) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ack <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         cfg_ack <= wr_valid;
         cfg_err <= cfg_we && !wr_valid;
      end
   end

`ifdef LED_BREATHE_EN
   logic [PWM_BITS-1:0] pwm_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end
`endif

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      mode_t      mode;
      logic [7:0] period;
      logic [7:0] tcnt;
      logic       phase;
      logic       sel;
      logic       timed;
      logic       expire;
      logic [7:0] last;
      logic       chan_lit;

      // A stored period of 0 behaves like 1, so the wrap point never underflows.
      assign last   = (period == 8'd0) ? 8'd0 : period - 8'd1;
      assign sel    = wr_valid && (cfg_ch == CW'(i));
      assign timed  = (mode == MODE_BLINK) || (mode == MODE_BREATHE);
      assign expire = tick && timed && (tcnt == last);

      // A write to this channel takes priority over a coincident tick.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mode   <= (HEARTBEAT && (i == 0)) ? MODE_BLINK : MODE_OFF;
            period <= (HEARTBEAT && (i == 0)) ? 8'd250 : 8'd0;
            tcnt   <= 8'd0;
            phase  <= 1'b0;
         end else if (sel) begin
            mode   <= mode_t'(cfg_mode);
            period <= cfg_period;
            tcnt   <= 8'd0;
            phase  <= 1'b0;
         end else if (expire) begin
            tcnt   <= 8'd0;
            phase  <= ~phase;
         end else if (tick && timed) begin
            tcnt   <= tcnt + 8'd1;
         end
      end

`ifdef LED_BREATHE_EN
      logic [PWM_BITS-1:0] level;
      logic                dir_down;

      // Direction flips on the step that lands on an endpoint, so each endpoint lasts one step.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            level    <= '0;
            dir_down <= 1'b0;
         end else if (sel) begin
            level    <= '0;
            dir_down <= 1'b0;
         end else if (expire && (mode == MODE_BREATHE)) begin
            if (!dir_down) begin
               level <= level + 1'b1;
               if (level == {PWM_BITS{1'b1}} - 1'b1) dir_down <= 1'b1;
            end else begin
               level <= level - 1'b1;
               if (level == PWM_BITS'(1)) dir_down <= 1'b0;
            end
         end
      end

      always_comb begin
         chan_lit = 1'b0;
         case (mode)
            MODE_OFF:     chan_lit = 1'b0;
            MODE_ON:      chan_lit = 1'b1;
            MODE_BLINK:   chan_lit = phase;
            MODE_BREATHE: chan_lit = (pwm_cnt < level);
            default:      chan_lit = 1'b0;
         endcase
      end
`else
      always_comb begin
         chan_lit = 1'b0;
         case (mode)
            MODE_OFF:     chan_lit = 1'b0;
            MODE_ON:      chan_lit = 1'b1;
            MODE_BLINK:   chan_lit = phase;
            MODE_BREATHE: chan_lit = 1'b1;
            default:      chan_lit = 1'b0;
         endcase
      end
`endif

      assign lit[i] = chan_lit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_o <= {NUM_LEDS{ACTIVE_LOW}};
      end else begin
         led_o <= lit ^ {NUM_LEDS{ACTIVE_LOW}};
      end
   end

endmodule
